// File: rtl/gpio_cmd_seq.sv
// gpio_cmd_seq: decodes four-phase GPIO command words into kernel, size, pixel,
// read and run operations for the convolution datapath, and reports status back.
module gpio_cmd_seq #(
    parameter int GPIO_D      = 32,
    parameter int N_CH        = 2,
    parameter int KSIZE       = 3,
    parameter int BITS_IMAGEN = 8,
    parameter int BITS_DATA   = 13,
    parameter int NB_ADDRESS  = 10
) (
    input  logic                           i_CLK,
    input  logic                           i_rst,
    input  logic [GPIO_D-1:0]              i_gpio,
    input  logic                           i_eop,
    input  logic [BITS_DATA-1:0]           i_rd_data,
    input  logic                           i_rd_valid,
    output logic [GPIO_D-1:0]              o_gpio,
    output logic [KSIZE*BITS_IMAGEN-1:0]   o_kernel,
    output logic [N_CH-1:0]                o_kernel_we,
    output logic [NB_ADDRESS-1:0]          o_img_len,
    output logic [KSIZE*BITS_IMAGEN-1:0]   o_pix,
    output logic                           o_pix_valid,
    output logic [NB_ADDRESS-1:0]          o_pix_addr,
    output logic                           o_rd_req,
    output logic [NB_ADDRESS-1:0]          o_rd_addr,
    output logic                           o_run,
    output logic                           o_busy
);
    localparam int KW = KSIZE * BITS_IMAGEN;
    localparam int RW = KSIZE > 1 ? $clog2(KSIZE) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(KSIZE - 1);
    localparam logic [RW-1:0] ROW_ONE = RW'(1);
    localparam logic [NB_ADDRESS-1:0] A_ONE = NB_ADDRESS'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KLOAD = 3'd1,
        SIZE  = 3'd2,
        ILOAD = 3'd3,
        READ  = 3'd4,
        RUN   = 3'd5
    } state_t;

    state_t state, state_d;
    logic v_q, ack, err, k_done, sz_done;
    logic [RW-1:0] row;
    logic [BITS_DATA-1:0] rd_q;
    logic [2:0] cmd;
    logic [KW-1:0] payload;
    logic valid, acc, clr, busy_st, exec, rd_done, eop_done;
    logic unused_bits;

    assign cmd         = i_gpio[GPIO_D-1 -: 3];
    assign valid       = i_gpio[GPIO_D-4];
    assign payload     = i_gpio[KW:1];
    assign unused_bits = ^i_gpio;
    assign acc         = valid & ~v_q;
    assign clr         = acc & (cmd == 3'd7);
    assign busy_st     = (state == READ) || (state == RUN);
    // commands arriving while a read or frame is outstanding are overruns
    assign exec        = acc & ~clr & ~busy_st;
    assign rd_done     = (state == READ) & i_rd_valid & ~clr;
    assign eop_done    = (state == RUN) & i_eop & ~clr;

    always_ff @(posedge i_CLK or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (clr) state_d = IDLE;
        else if (exec) begin
            case (cmd)
                3'd0:    state_d = KLOAD;
                3'd1:    state_d = SIZE;
                3'd2:    state_d = ILOAD;
                3'd3:    state_d = READ;
                3'd4:    state_d = (k_done && sz_done) ? RUN : IDLE;
                default: state_d = IDLE;
            endcase
        end
        else if (rd_done || eop_done) state_d = IDLE;
        else if (!valid && (state == KLOAD || state == SIZE || state == ILOAD)) state_d = IDLE;
    end

    always_ff @(posedge i_CLK or negedge i_rst) begin
        if (!i_rst) begin
            v_q         <= 1'b0;
            ack         <= 1'b0;
            err         <= 1'b0;
            k_done      <= 1'b0;
            sz_done     <= 1'b0;
            row         <= '0;
            rd_q        <= '0;
            o_kernel    <= '0;
            o_kernel_we <= '0;
            o_img_len   <= '0;
            o_pix       <= '0;
            o_pix_valid <= 1'b0;
            o_pix_addr  <= '0;
            o_rd_req    <= 1'b0;
            o_rd_addr   <= '0;
            o_run       <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            v_q         <= valid;
            o_kernel_we <= '0;
            o_pix_valid <= 1'b0;
            o_rd_req    <= 1'b0;
            o_run       <= 1'b0;
            // column address advances once its strobe has been presented
            if (o_pix_valid) o_pix_addr <= (o_pix_addr == o_img_len - A_ONE) ? '0 : o_pix_addr + A_ONE;
            if ((acc && !(exec && cmd == 3'd3)) || rd_done) ack <= 1'b1;
            else if (!valid) ack <= 1'b0;
            if (clr) begin
                err        <= 1'b0;
                k_done     <= 1'b0;
                sz_done    <= 1'b0;
                row        <= '0;
                o_pix_addr <= '0;
                o_rd_addr  <= '0;
                o_busy     <= 1'b0;
            end else begin
                if (acc && busy_st) err <= 1'b1;
                if (exec) begin
                    case (cmd)
                        3'd0: begin
                            o_kernel    <= payload;
                            o_kernel_we <= '1;
                            row         <= (row == ROW_LAST) ? '0 : row + ROW_ONE;
                            if (row == ROW_LAST) k_done <= 1'b1;
                        end
                        3'd1: begin
                            if (payload[NB_ADDRESS-1:0] != '0) begin
                                o_img_len  <= payload[NB_ADDRESS-1:0];
                                sz_done    <= 1'b1;
                                o_pix_addr <= '0;
                            end else err <= 1'b1;
                        end
                        3'd2: begin
                            if (sz_done) begin
                                o_pix       <= payload;
                                o_pix_valid <= 1'b1;
                            end else err <= 1'b1;
                        end
                        3'd3: o_rd_req <= 1'b1;
                        3'd4: begin
                            if (k_done && sz_done) begin
                                o_run  <= 1'b1;
                                o_busy <= 1'b1;
                            end else err <= 1'b1;
                        end
                        default: err <= 1'b1;
                    endcase
                end
                if (rd_done) begin
                    rd_q      <= i_rd_data;
                    o_rd_addr <= (o_rd_addr == o_img_len - A_ONE) ? '0 : o_rd_addr + A_ONE;
                end
                if (eop_done) begin
                    o_busy    <= 1'b0;
                    o_rd_addr <= '0;
                end
            end
        end
    end

    always_comb begin
        o_gpio                   = '0;
        o_gpio[GPIO_D-1 -: 3]    = err ? 3'd7 : 3'(state);
        o_gpio[GPIO_D-4]         = ack;
        o_gpio[GPIO_D-5]         = err;
        o_gpio[BITS_DATA-1:0]    = rd_q;
    end
endmodule

// File: tb/tb_gpio_cmd_seq.sv
// tb_gpio_cmd_seq: directed scenarios plus randomized command traffic, checked
// every cycle against a transaction-level model of the command sequencer.
module tb_gpio_cmd_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] gpio = '0;
    logic        eop = 1'b0;
    logic [12:0] rd_data = '0;
    logic        rd_valid = 1'b0;
    logic [31:0] o_gpio;
    logic [23:0] o_kernel, o_pix;
    logic [1:0]  o_kernel_we;
    logic [9:0]  o_img_len, o_pix_addr, o_rd_addr;
    logic        o_pix_valid, o_rd_req, o_run, o_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int run_cnt = 0;
    bit chk_en = 0;

    gpio_cmd_seq dut (
        .i_CLK(clk), .i_rst(rst), .i_gpio(gpio), .i_eop(eop),
        .i_rd_data(rd_data), .i_rd_valid(rd_valid),
        .o_gpio(o_gpio), .o_kernel(o_kernel), .o_kernel_we(o_kernel_we),
        .o_img_len(o_img_len), .o_pix(o_pix), .o_pix_valid(o_pix_valid),
        .o_pix_addr(o_pix_addr), .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr),
        .o_run(o_run), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // model: mode holds the reported state code (0 idle,1 kload,2 size,3 iload,4 read,5 run)
    logic       m_vq, m_ack, m_err, m_kdone, m_sz, m_busy, m_pend;
    logic       m_kwe, m_pixv, m_rdreq, m_run;
    logic [2:0] m_mode;
    int         m_rows;
    logic [9:0] m_len, m_pixa, m_rda;
    logic [12:0] m_rdq;
    logic [23:0] m_kernel, m_pix;

    task automatic m_zero();
        {m_vq, m_ack, m_err, m_kdone, m_sz, m_busy, m_pend} = '0;
        {m_kwe, m_pixv, m_rdreq, m_run} = '0;
        m_mode = 0; m_rows = 0; m_len = 0; m_pixa = 0; m_rda = 0;
        m_rdq = 0; m_kernel = 0; m_pix = 0;
    endtask

    task automatic m_step();
        logic v, a, ack_set;
        logic [2:0] c, old;
        logic [23:0] p;
        v = gpio[28]; c = gpio[31:29]; p = gpio[24:1];
        a = v && !m_vq; old = m_mode; ack_set = 0;
        {m_kwe, m_pixv, m_rdreq, m_run} = '0;
        if (m_pend) begin
            m_pixa = (m_pixa == m_len - 10'd1) ? 10'd0 : m_pixa + 10'd1;
            m_pend = 0;
        end
        if (a && c == 3'd7) begin
            m_err = 0; m_kdone = 0; m_sz = 0; m_rows = 0; m_pixa = 0; m_rda = 0;
            m_busy = 0; m_mode = 0; ack_set = 1;
        end else begin
            if (a && (old == 4 || old == 5)) begin
                m_err = 1; ack_set = 1;
            end else if (a) begin
                ack_set = (c != 3'd3);
                case (c)
                    3'd0: begin
                        m_kernel = p; m_kwe = 1; m_rows++; m_mode = 1;
                        if (m_rows == 3) begin m_rows = 0; m_kdone = 1; end
                    end
                    3'd1: begin
                        m_mode = 2;
                        if (p[9:0] != 0) begin m_len = p[9:0]; m_sz = 1; m_pixa = 0; end
                        else m_err = 1;
                    end
                    3'd2: begin
                        m_mode = 3;
                        if (m_sz) begin m_pix = p; m_pixv = 1; m_pend = 1; end
                        else m_err = 1;
                    end
                    3'd3: begin m_rdreq = 1; m_mode = 4; end
                    3'd4: begin
                        if (m_kdone && m_sz) begin m_run = 1; m_busy = 1; m_mode = 5; end
                        else m_err = 1;
                    end
                    default: m_err = 1;
                endcase
            end
            if (old == 4 && rd_valid) begin
                m_rdq = rd_data; ack_set = 1; m_mode = 0;
                m_rda = (m_rda == m_len - 10'd1) ? 10'd0 : m_rda + 10'd1;
            end
            if (old == 5 && eop) begin m_busy = 0; m_rda = 0; m_mode = 0; end
        end
        if (old >= 1 && old <= 3 && !v) m_mode = 0;
        m_ack = ack_set ? 1'b1 : (v ? m_ack : 1'b0);
        m_vq = v;
    endtask

    initial m_zero();

    always @(posedge clk or negedge rst) begin
        if (!rst) m_zero();
        else m_step();
    end

    function automatic logic [31:0] exp_gpio();
        logic [31:0] e;
        e = '0;
        e[31:29] = m_err ? 3'd7 : m_mode;
        e[28] = m_ack;
        e[27] = m_err;
        e[12:0] = m_rdq;
        return e;
    endfunction

    always @(negedge clk) begin
        if (o_run) run_cnt++;
        if (chk_en) begin
            chk("m_gpio", o_gpio, exp_gpio());
            chk("m_kernel", o_kernel, m_kernel);
            chk("m_kernel_we", o_kernel_we, m_kwe ? 2'b11 : 2'b00);
            chk("m_img_len", o_img_len, m_len);
            chk("m_pix", o_pix, m_pix);
            chk("m_pix_valid", o_pix_valid, m_pixv);
            chk("m_pix_addr", o_pix_addr, m_pixa);
            chk("m_rd_req", o_rd_req, m_rdreq);
            chk("m_rd_addr", o_rd_addr, m_rda);
            chk("m_run", o_run, m_run);
            chk("m_busy", o_busy, m_busy);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] gw(input logic [2:0] c, input logic [23:0] p, input logic [3:0] j);
        logic [31:0] w;
        w = '0;
        w[31:29] = c;
        w[28] = 1'b1;
        w[27:25] = j[3:1];
        w[24:1] = p;
        w[0] = j[0];
        return w;
    endfunction

    task automatic put(input logic [2:0] c, input logic [23:0] p);
        gpio = gw(c, p, 4'd0);
        tick();
    endtask

    task automatic drop();
        gpio[28] = 1'b0;
        tick();
    endtask

    logic [23:0] kp [3] = '{24'h123456, 24'hABCDEF, 24'h0F0F0F};
    int pa [5] = '{0, 1, 2, 3, 0};

    initial begin
        tick(3);
        chk("rst_gpio", o_gpio, 32'h0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_kwe", o_kernel_we, 2'b00);
        chk_en = 1;
        rst = 1'b1;
        tick(2);
        // run before any size load is rejected
        put(3'd4, 24'h0);
        chk("r050_code", o_gpio[31:29], 3'd7);
        chk("r050_err", o_gpio[27], 1'b1);
        chk("r050_run", o_run, 1'b0);
        chk("r050_ack", o_gpio[28], 1'b1);
        drop();
        chk("r050_ackfall", o_gpio[28], 1'b0);
        put(3'd7, 24'h0);
        chk("clr_code", o_gpio[31:29], 3'd0);
        chk("clr_err", o_gpio[27], 1'b0);
        drop();
        for (int k = 0; k < 3; k++) begin
            put(3'd0, kp[k]);
            chk("r048_we", o_kernel_we, 2'b11);
            chk("r048_kernel", o_kernel, kp[k]);
            chk("r048_code", o_gpio[31:29], 3'd1);
            drop();
            chk("r048_idle", o_gpio[31:29], 3'd0);
        end
        put(3'd1, 24'd4);
        chk("r049_len", o_img_len, 10'd4);
        chk("r049_code", o_gpio[31:29], 3'd2);
        drop();
        for (int i = 0; i < 5; i++) begin
            put(3'd2, 24'hA00000 + 24'(i));
            chk("r049_pv", o_pix_valid, 1'b1);
            chk("r049_addr", o_pix_addr, 10'(pa[i]));
            chk("r049_pix", o_pix, 24'hA00000 + 24'(i));
            drop();
        end
        put(3'd3, 24'h0);
        chk("r052_req", o_rd_req, 1'b1);
        chk("r052_raddr", o_rd_addr, 10'd0);
        chk("r052_noack", o_gpio[28], 1'b0);
        chk("r052_code", o_gpio[31:29], 3'd4);
        tick(4);
        rd_data = 13'h1ABC;
        rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0;
        chk("r052_ack", o_gpio[28], 1'b1);
        chk("r052_data", o_gpio[12:0], 13'h1ABC);
        chk("r052_idle", o_gpio[31:29], 3'd0);
        chk("r052_rinc", o_rd_addr, 10'd1);
        drop();
        chk("r052_ackfall", o_gpio[28], 1'b0);
        put(3'd4, 24'h0);
        chk("r051_run", o_run, 1'b1);
        chk("r051_busy", o_busy, 1'b1);
        chk("r051_code", o_gpio[31:29], 3'd5);
        drop();
        tick(19);
        eop = 1'b1;
        tick();
        eop = 1'b0;
        chk("r051_nbusy", o_busy, 1'b0);
        chk("r051_idle", o_gpio[31:29], 3'd0);
        chk("r051_raddr", o_rd_addr, 10'd0);
        chk("r051_runs", run_cnt, 1);
        put(3'd1, 24'd0);
        chk("zlen_err", o_gpio[27], 1'b1);
        chk("zlen_len", o_img_len, 10'd4);
        chk("zlen_code", o_gpio[31:29], 3'd7);
        drop();
        put(3'd4, 24'h0);
        chk("r053_busy", o_busy, 1'b1);
        chk("r053_run", o_run, 1'b1);
        drop();
        tick(3);
        rst = 1'b0;
        #1;
        chk("r053_gpio", o_gpio, 32'h0);
        chk("r053_nbusy", o_busy, 1'b0);
        chk("r053_kernel", o_kernel, 24'h0);
        chk("r053_len", o_img_len, 10'd0);
        tick(2);
        rst = 1'b1;
        tick();
        eop = 1'b1;
        tick();
        eop = 1'b0;
        tick(3);
        chk("r053_after_busy", o_busy, 1'b0);
        chk("r053_after_gpio", o_gpio, 32'h0);
        chk("r053_runs", run_cnt, 2);
        for (int t = 0; t < 600; t++) begin
            int r, hold, gap;
            logic [2:0] c;
            logic [23:0] p;
            r = $urandom_range(0, 99);
            c = r < 25 ? 3'd0 : r < 40 ? 3'd1 : r < 65 ? 3'd2 : r < 75 ? 3'd3 :
                r < 85 ? 3'd4 : r < 89 ? 3'(5 + (r & 1)) : 3'd7;
            p = 24'($urandom);
            if (c == 3'd1) p[9:0] = 10'($urandom_range(0, 6));
            gpio = gw(c, p, 4'($urandom));
            hold = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) begin
                rd_valid = ($urandom_range(0, 3) == 0);
                rd_data = 13'($urandom);
                eop = ($urandom_range(0, 4) == 0);
                tick();
            end
            gpio[28] = 1'b0;
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                rd_valid = ($urandom_range(0, 3) == 0);
                rd_data = 13'($urandom);
                eop = ($urandom_range(0, 4) == 0);
                tick();
            end
            rd_valid = 1'b0;
            eop = 1'b0;
            if ($urandom_range(0, 79) == 0) begin
                rst = 1'b0;
                tick($urandom_range(1, 2));
                rst = 1'b1;
            end
        end
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
